// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch front end: pc, imem req/ack port, stall hold, redirect drop
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        res,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] order_out
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] drop_addr_q, drop_addr_n;
    logic [31:0] hold_q, hold_n;
    logic [31:0] target;

    assign target = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_addr_q <= 32'h0000_0000;
            hold_q      <= NOP;
        end else begin
            state_q     <= state_n;
            pc_q        <= pc_n;
            drop_addr_q <= drop_addr_n;
            hold_q      <= hold_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        pc_n        = pc_q;
        drop_addr_n = drop_addr_q;
        hold_n      = hold_q;
        imem_req    = 1'b0;
        imem_addr   = pc_q;
        pc_out      = pc_q;
        order_out   = NOP;
        case (state_q)
            S_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_n = target;
                    if (!imem_ack) begin
                        // the in-flight fetch must still complete before the new one issues
                        drop_addr_n = pc_q;
                        state_n     = S_DROP;
                    end
                end else if (imem_ack) begin
                    order_out = imem_rdata;
                    if (stall) begin
                        hold_n  = imem_rdata;
                        state_n = S_HOLD;
                    end else begin
                        pc_n = pc_q + 32'd4;
                    end
                end
            end
            S_HOLD: begin
                order_out = hold_q;
                if (redirect) begin
                    pc_n    = target;
                    state_n = S_REQ;
                end else if (!stall) begin
                    pc_n    = pc_q + 32'd4;
                    state_n = S_REQ;
                end
            end
            S_DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
                if (redirect) begin
                    pc_n = target;
                end
                if (imem_ack) begin
                    state_n = S_REQ;
                end
            end
            default: begin
                state_n = S_REQ;
            end
        endcase
        // registers are already forced by the async reset; only the request and data path need gating
        if (!res) begin
            imem_req  = 1'b0;
            order_out = NOP;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;

    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam logic [31:0] NOPW = 32'h0000_0000;

    logic        clk;
    logic        res;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] order_out;

    if_fetch_unit #(.RESET_PC(RPC), .NOP(NOPW)) dut (
        .clk(clk), .res(res), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_out(pc_out),
        .order_out(order_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          captures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] gen_next;
    bit          mem_busy = 0;
    int          mem_rem = 0;
    int          min_lat = 0;
    int          max_lat = 0;
    int          p_stall = 0;
    int          p_redir = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    // instruction words always have low bits 2'b11, so they can never look like a NOP bubble
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hA5A5_0000) | 32'h0000_0003;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(gen_next);
            gen_next = gen_next + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] a);
        exp_q.delete();
        gen_next = a;
        refill();
    endtask

    task automatic cycle();
        logic [31:0] t;
        @(posedge clk);
        #1;
        stall    = ($urandom_range(0, 99) < p_stall);
        redirect = ($urandom_range(0, 99) < p_redir);
        redirect_pc = $urandom;
        if (redirect) begin
            case ($urandom_range(0, 3))
                0: t = 32'h0000_0203;
                1: t = 32'hFFFF_FFFA;
                2: t = {16'h0000, 16'($urandom)};
                default: t = $urandom;
            endcase
            redirect_pc = t;
            restart({t[31:2], 2'b00});
        end
        #1;
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_rem  = $urandom_range(min_lat, max_lat);
            end
            if (mem_rem == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                mem_busy   = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                mem_rem--;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            mem_busy   = 0;
        end
        refill();
    endtask

    // monitor: IF/ID captures whenever it is not stalled, not flushed and sees a non-bubble word
    always @(negedge clk) begin
        if (!res) begin
            check("rst_req", {31'h0, imem_req}, 32'h0);
            check("rst_order", order_out, NOPW);
            check("rst_pc", pc_out, RPC);
            prev_wait = 1'b0;
        end else begin
            if (prev_wait && imem_req)
                check("addr_stable", imem_addr, prev_addr);
            if (!stall && !redirect && order_out !== NOPW) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty actual=capture required=none");
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("cap_pc", pc_out, e);
                    check("cap_instr", order_out, mem_word(e));
                end
                captures++;
            end
            prev_wait = imem_req && !imem_ack;
            prev_addr = imem_addr;
        end
    end

    initial begin
        int cap0;
        int n;
        res = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        restart(RPC);
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", imem_addr, RPC);
        #1 res = 1'b1;

        // zero-wait, no stall: one instruction per cycle
        min_lat = 0; max_lat = 0; p_stall = 0; p_redir = 0;
        cap0 = captures;
        repeat (20) cycle();
        @(negedge clk); #1;
        check("zero_wait_rate", 32'(captures - cap0), 32'd20);

        // fixed 2-cycle latency: NOP, NOP, valid
        min_lat = 2; max_lat = 2;
        cap0 = captures;
        repeat (30) cycle();
        @(negedge clk); #1;
        check("lat2_rate", 32'(captures - cap0), 32'd10);

        // random latency, stalls and redirects
        min_lat = 0; max_lat = 3; p_stall = 30; p_redir = 10;
        repeat (2000) cycle();

        // async reset while a request is waiting
        min_lat = 3; max_lat = 3; p_stall = 0; p_redir = 0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(imem_req && !imem_ack) && n < 20);
        check("found_wait", {31'h0, imem_req && !imem_ack}, 32'h1);
        #1 res = 1'b0;
        #1;
        check("async_req", {31'h0, imem_req}, 32'h0);
        check("async_pc", pc_out, RPC);
        check("async_addr", imem_addr, RPC);
        check("async_order", order_out, NOPW);
        imem_ack = 1'b0;
        mem_busy = 0;
        stall = 1'b0; redirect = 1'b0;
        restart(RPC);
        repeat (2) @(posedge clk);
        #2 res = 1'b1;
        min_lat = 0; max_lat = 1;
        repeat (40) cycle();
        @(negedge clk); #1;
        check("liveness", {31'h0, captures > 400}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end that produces the pc/instruction pair consumed by the IF/ID pipeline register. Owns the program counter, drives a request/acknowledge instruction-memory port, and honours the IF/ID stall flag without losing or duplicating an instruction. Applies branch/jump redirects from later stages and inserts NOP bubbles while memory is busy or a stale fetch is being dropped.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP, 32'h0000_0000: bubble encoding driven on order_out when no valid instruction is available.
- clk  in  1  rising-edge clock.
- res  in  1  reset; asynchronous, active-low (0 = reset).
- stall  in  1  same signal as the IF/ID flag; 1 = IF/ID holds and will not capture this cycle.
- redirect  in  1  1 = replace the fetch stream with redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- imem_req  out  1  fetch request; level, held until imem_ack.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  memory returns imem_rdata this cycle; may be asserted in the same cycle as imem_req (zero-wait).
- imem_rdata  in  32  instruction word, valid only with imem_ack.
- pc_out  out  32  to IF/ID pc_in.
- order_out  out  32  to IF/ID order_in.

## Operation
- Registers: pc (next-in-order fetch address), drop_addr, buf (held instruction), state ∈ {REQ, HOLD, DROP}.
- Outputs pc_out/order_out/imem_* are combinational from state, registers and the current inputs; IF/ID samples them at the edge.
- REQ: imem_req=1, imem_addr=pc, pc_out=pc.
  - redirect=1: order_out=NOP; pc←{redirect_pc[31:2],2'b00}; if imem_ack stay REQ (word discarded), else drop_addr←pc, go DROP.
  - imem_ack=1, stall=0: order_out=imem_rdata; pc←pc+4; stay REQ.
  - imem_ack=1, stall=1: order_out=imem_rdata (ignored by IF/ID); buf←imem_rdata; go HOLD.
  - imem_ack=0: order_out=NOP; no register change.
- HOLD: imem_req=0; pc_out=pc; order_out=buf.
  - redirect=1: pc←redirect target; go REQ.
  - stall=0: IF/ID captures buf this edge; pc←pc+4; go REQ.
  - stall=1: stay.
- DROP: imem_req=1, imem_addr=drop_addr; order_out=NOP; pc_out=pc.
  - imem_ack=1: go REQ (returned word discarded).
  - redirect=1 (with or without ack): pc←new target; drop_addr unchanged.
- Priority: redirect > stall > ack handling. stall is irrelevant while order_out=NOP.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).

## Timing
- Reset (res=0, asynchronous): state=REQ, pc=RESET_PC, drop_addr=0, buf=NOP. While res=0: imem_req=0, imem_addr=RESET_PC, pc_out=RESET_PC, order_out=NOP.
- First request asserted in the first cycle with res=1; reset deassertion mid-request abandons it (memory must tolerate a dropped request).
- Zero-wait memory, no stall: one instruction per cycle; pc_out increments by 4 each cycle.
- N-cycle memory latency: N cycles of NOP on order_out, then one valid instruction; next request starts the following cycle.
- Redirect latency: request to the target issued the cycle after redirect, or after the outstanding stale ack in DROP.
- Never more than one outstanding request; imem_addr never changes while imem_req=1 and imem_ack=0.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory returning addr^0xA5A5_0000, stall=0 → pc_out 0x100,0x104,0x108… each cycle, order_out matching; during res=0 imem_req=0, order_out=NOP.
- Memory with 2-cycle ack latency → order_out=NOP,NOP,valid repeating; imem_addr stable across the wait cycles.
- stall=1 for 3 cycles coincident with ack at 0x108 → state HOLD, imem_req=0, order_out=word@0x108 held; after stall drops next fetch is 0x10C; no word skipped or repeated.
- redirect to 0x203 while a 3-cycle request to 0x110 is outstanding → imem_addr stays 0x110 until ack, its data never appears on order_out, next request is 0x200.
- redirect and stall both asserted in HOLD → redirect wins, next request at target; pc=0xFFFF_FFFC fetched → next fetch 0x0000_0000.
- res pulsed low mid-wait → imem_req drops immediately, outputs return to RESET_PC/NOP asynchronously, fetch restarts at RESET_PC.
